// File: rtl/video_pkg.sv
// Shared video-timing types and constants for the 3x3 filter front end.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BRD_TOP   = 3;
  localparam int BRD_BOT   = 2;
  localparam int BRD_LEFT  = 1;
  localparam int BRD_RIGHT = 0;

  localparam int DEF_IMG_W = 1280;
  localparam int DEF_IMG_H = 720;

endpackage

// File: rtl/line_buf_window_ctrl_if.sv
// Camera-side timing inputs and line-buffer / window-stage outputs of the window controller.
interface line_buf_window_ctrl_if #(
  parameter int CNT_W = 12
);

  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic             lb_clken;
  logic             lb_href;
  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic             win_valid;
  logic [3:0]       win_border;
  logic             frame_done;
  logic             line_len_err;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    input  lb_clken, lb_href, col_cnt, row_cnt,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  win_valid, win_border, frame_done, line_len_err
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    output lb_clken, lb_href, col_cnt, row_cnt,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output win_valid, win_border, frame_done, line_len_err
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous clear; o_q is i_d delayed DEPTH cycles.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/line_buf_window_ctrl.sv
// Frame/line sequencer for the two-line buffer: position counters, buffer enables and
// LAT-aligned sync/window flags. Optional LINE_LEN_CHK_EN adds a per-frame line length check.
module line_buf_window_ctrl
  import video_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = 12,
  parameter int LAT   = 3
) (
  input logic clock,
  input logic rst,
  line_buf_window_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_vsync_d;
  logic             r_href_d;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_frame_done;
  logic             w_vsync_rise;
  logic             w_href_fall;
  logic             w_pix;
  logic             w_in_frame;
  logic             w_win_in;
  logic [3:0]       w_border_in;
  logic [2:0]       w_post;
  logic [4:0]       w_win_q;

  assign w_vsync_rise = bus.per_frame_vsync & ~r_vsync_d;
  assign w_href_fall  = ~bus.per_frame_href & r_href_d;
  assign w_pix        = bus.per_frame_href & bus.per_frame_clken;
  assign w_in_frame   = (r_state == FRAME);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_vsync_rise) w_next_state = FRAME;
        else              w_next_state = IDLE;
      end
      FRAME: begin
        if (w_vsync_rise)                         w_next_state = FRAME;
        else if (w_href_fall && r_row == ROW_MAX) w_next_state = DONE;
        else                                      w_next_state = FRAME;
      end
      DONE: begin
        if (w_vsync_rise) w_next_state = FRAME;
        else              w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // A vsync rise outranks every counter update, including a coincident href fall.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_col        <= ZERO;
      r_row        <= ZERO;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync_d    <= bus.per_frame_vsync;
      r_href_d     <= bus.per_frame_href;
      r_frame_done <= (w_next_state == DONE);
      if (w_vsync_rise) begin
        r_col <= ZERO;
        r_row <= ZERO;
      end else if (w_in_frame && w_href_fall) begin
        r_col <= ZERO;
        if (r_row != ROW_MAX) r_row <= r_row + CNT_W'(1);
      end else if (w_in_frame && w_pix && r_col != COL_MAX) begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_border_in            = 4'b0000;
    w_border_in[BRD_TOP]   = (r_row < TWO);
    w_border_in[BRD_BOT]   = (r_row == ROW_MAX);
    w_border_in[BRD_LEFT]  = (r_col < TWO);
    w_border_in[BRD_RIGHT] = (r_col == ZERO);
  end

  assign w_win_in = w_pix & (r_row >= TWO) & (r_col >= TWO);

  sync_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_sync_dly (
    .clock (clock),
    .rst   (rst),
    .i_d   ({bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken}),
    .o_q   (w_post)
  );

  sync_delay_line #(.WIDTH(5), .DEPTH(LAT)) u_win_dly (
    .clock (clock),
    .rst   (rst),
    .i_d   ({w_win_in, w_border_in}),
    .o_q   (w_win_q)
  );

  assign bus.lb_clken         = w_pix & w_in_frame;
  assign bus.lb_href          = bus.per_frame_href & w_in_frame;
  assign bus.col_cnt          = r_col;
  assign bus.row_cnt          = r_row;
  assign bus.post_frame_vsync = w_post[2];
  assign bus.post_frame_href  = w_post[1];
  assign bus.post_frame_clken = w_post[0];
  assign bus.win_valid        = w_win_q[4];
  assign bus.win_border       = w_win_q[3:0];
  assign bus.frame_done       = r_frame_done;

`ifdef LINE_LEN_CHK_EN
  localparam int              LEN_W   = CNT_W + 1;
  localparam logic [LEN_W-1:0] LEN_EXP = LEN_W'(IMG_W);

  logic [LEN_W-1:0] r_len_cnt;
  logic             r_len_err;

  // Unsaturated pixel count so over-long lines are caught as well as short ones.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_len_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (w_vsync_rise) begin
      r_len_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (w_in_frame && w_href_fall) begin
      r_len_cnt <= '0;
      if (r_len_cnt != LEN_EXP) r_len_err <= 1'b1;
    end else if (w_in_frame && w_pix) begin
      r_len_cnt <= r_len_cnt + LEN_W'(1);
    end
  end

  assign bus.line_len_err = r_len_err;
`else
  assign bus.line_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// Directed bench for line_buf_window_ctrl (IMG_W=8, IMG_H=4, LAT=3); honours LINE_LEN_CHK_EN.
module tb_line_buf_window_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int L = 3;
`ifdef LINE_LEN_CHK_EN
  localparam logic LLC = 1'b1;
`else
  localparam logic LLC = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  line_buf_window_ctrl_if #(.CNT_W(12)) bus ();

  line_buf_window_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(12), .LAT(L)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Per-cycle record of driven inputs and the window flags they should produce LAT cycles later.
  logic [2:0] hist  [0:4095];
  logic       vhist [0:4095];
  logic [3:0] bhist [0:4095];
  int   last_rst = -1;
  int   exp_row = 0;
  int   exp_col = 0;
  int   valid_pulses = 0;
  int   done_pulses = 0;
  int   done_mark = 0;
  logic [3:0] first_border = 4'hf;
  bit   got_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic c, input logic r);
    logic [2:0] ep;
    logic       ev;
    logic [3:0] eb;
    int         src;
    @(posedge clock);
    #1;
    rst = r;
    bus.per_frame_vsync = v;
    bus.per_frame_href  = h;
    bus.per_frame_clken = c;
    #1;
    src = cyc - L;
    if (src >= 0 && src > last_rst) begin
      ep = hist[src];
      ev = vhist[src];
      eb = bhist[src];
    end else begin
      ep = 3'b000;
      ev = 1'b0;
      eb = 4'b0000;
    end
    chk("post_sync", {29'd0, bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken}, {29'd0, ep});
    chk("win_valid", {31'd0, bus.win_valid}, {31'd0, ev});
    if (ev) chk("win_border", {28'd0, bus.win_border}, {28'd0, eb});
    if (bus.win_valid === 1'b1) begin
      valid_pulses++;
      if (!got_first) begin
        got_first = 1'b1;
        first_border = bus.win_border;
      end
    end
    if (bus.frame_done === 1'b1) done_pulses++;
    hist[cyc]  = {v, h, c};
    vhist[cyc] = h & c & (exp_row >= 2) & (exp_col >= 2);
    bhist[cyc] = {exp_row < 2, exp_row == H - 1, exp_col < 2, exp_col == 0};
    if (r) last_rst = cyc;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    blank(2);
  endtask

  // One href-high line: a pixel strobe every (gap+1) cycles, npix strobes in total.
  task automatic line(input int row, input int npix, input int gap, input logic in_frame);
    int c;
    logic pix;
    c = 0;
    for (int k = 0; k < npix * (gap + 1); k++) begin
      pix = (k % (gap + 1) == 0);
      exp_row = in_frame ? row : 0;
      exp_col = in_frame ? ((c > W - 1) ? W - 1 : c) : 0;
      step(1'b0, 1'b1, pix, 1'b0);
      chk("lb_clken", {31'd0, bus.lb_clken}, {31'd0, in_frame & pix});
      chk("lb_href", {31'd0, bus.lb_href}, {31'd0, in_frame});
      if (pix) begin
        chk("col_cnt", {20'd0, bus.col_cnt}, exp_col);
        chk("row_cnt", {20'd0, bus.row_cnt}, exp_row);
        c++;
      end
    end
  endtask

  task automatic rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      line(r, W, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_at_fall", {31'd0, bus.frame_done}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (r == H - 1) begin
        chk("done_pulse", {31'd0, bus.frame_done}, 32'd1);
      end else begin
        chk("row_adv", {20'd0, bus.row_cnt}, r + 1);
        chk("col_clr", {20'd0, bus.col_cnt}, 32'd0);
      end
      blank(2);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;

    // 1: reset held 5 cycles, outputs all zero
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_counters", {8'd0, bus.col_cnt, bus.row_cnt}, 32'd0);
      chk("rst_flags", {20'd0, bus.lb_clken, bus.lb_href, bus.post_frame_vsync, bus.post_frame_href,
                        bus.post_frame_clken, bus.win_valid, bus.win_border, bus.frame_done,
                        bus.line_len_err}, 32'd0);
    end
    blank(3);

    // 1/2: one full frame
    valid_pulses = 0;
    done_pulses  = 0;
    vsync_pulse();
    rows(0, H - 1);
    chk("done_after", {31'd0, bus.frame_done}, 32'd0);
    chk("done_count_f1", done_pulses, 32'd1);
    chk("valid_count_f1", valid_pulses, 32'd12);
    chk("first_border", {28'd0, first_border}, 32'd0);
    chk("row_sat", {20'd0, bus.row_cnt}, H - 1);
    chk("len_err_f1", {31'd0, bus.line_len_err}, 32'd0);

    // 3: gapped strobes, 9 pixels so the column counter also saturates
    vsync_pulse();
    line(0, 9, 1, 1'b1);
    chk("col_sat", {20'd0, bus.col_cnt}, W - 1);
    blank(4);

    // 4: vsync rises with href falling in row 2; vsync wins
    vsync_pulse();
    rows(0, 1);
    line(2, 4, 0, 1'b1);
    done_mark = done_pulses;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_row", {20'd0, bus.row_cnt}, 32'd0);
    chk("abort_col", {20'd0, bus.col_cnt}, 32'd0);
    blank(2);
    chk("abort_no_done", done_pulses - done_mark, 32'd0);
    rows(0, H - 1);
    chk("done_after_abort", done_pulses - done_mark, 32'd1);

    // 5: reset one cycle after a qualifying strobe in row 3
    vsync_pulse();
    rows(0, H - 2);
    done_mark = done_pulses;
    line(H - 1, 3, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_clken_after_rst", {31'd0, bus.post_frame_clken}, 32'd0);
      chk("win_valid_after_rst", {31'd0, bus.win_valid}, 32'd0);
    end
    chk("rst_col", {20'd0, bus.col_cnt}, 32'd0);
    chk("rst_row", {20'd0, bus.row_cnt}, 32'd0);
    line(0, 3, 0, 1'b0);
    blank(4);
    chk("no_done_after_rst", done_pulses - done_mark, 32'd0);

    // 6: short line 1 raises the sticky length error
    vsync_pulse();
    chk("len_err_start", {31'd0, bus.line_len_err}, 32'd0);
    line(0, W, 0, 1'b1);
    blank(4);
    line(1, 7, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("len_err_at_fall", {31'd0, bus.line_len_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("len_err_rise", {31'd0, bus.line_len_err}, {31'd0, LLC});
    blank(3);
    line(2, W, 0, 1'b1);
    blank(4);
    chk("len_err_hold", {31'd0, bus.line_len_err}, {31'd0, LLC});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("len_err_at_vsync", {31'd0, bus.line_len_err}, {31'd0, LLC});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("len_err_clear", {31'd0, bus.line_len_err}, 32'd0);
    blank(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
